// File: rtl/data_memory_be_pkg.sv
// rtl/data_memory_be_pkg.sv - shared FSM state type and size defaults for the byte-enable data memory
package memory_pkg;

    // Default geometry: 4 bytes per word, 8-bit byte address (64 words)
    localparam int W_DEFAULT      = 4;
    localparam int ADDR_W_DEFAULT = 8;

    // INIT clears the array one word per cycle, RUN serves requests
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_memory_be_if.sv
// rtl/data_memory_be_if.sv - request/response bundle between a requester and the data memory
interface data_memory_be_if
    import memory_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int Addr_W = ADDR_W_DEFAULT
);

    logic              inp_valid;
    logic              out_ready;
    logic              inp_write_enable;
    logic [W-1:0]      inp_byte_enable;
    logic [Addr_W-1:0] inp_address;
    logic [8*W-1:0]    inp_data;
    logic [8*W-1:0]    out_read_data;
    logic              out_read_valid;
    logic              out_misaligned;

    modport master (
        output inp_valid,
        output inp_write_enable,
        output inp_byte_enable,
        output inp_address,
        output inp_data,
        input  out_ready,
        input  out_read_data,
        input  out_read_valid,
        input  out_misaligned
    );

    modport slave (
        input  inp_valid,
        input  inp_write_enable,
        input  inp_byte_enable,
        input  inp_address,
        input  inp_data,
        output out_ready,
        output out_read_data,
        output out_read_valid,
        output out_misaligned
    );

endinterface

// File: rtl/data_memory_be.sv
// rtl/data_memory_be.sv - word-organised data memory with byte enables, self-clearing after reset
module data_memory_be
    import memory_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int Addr_W = ADDR_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    data_memory_be_if.slave bus
);

    localparam int OFF_W = $clog2(W);
    localparam int DEPTH = (2 ** Addr_W) / W;
    localparam int IDX_W = Addr_W - OFF_W;

    localparam logic [0:0] ST_INIT = INIT;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_cnt;
    logic [8*W-1:0]   mem [DEPTH];

    logic             accept;
    logic             misaligned;
    logic             hit_write;
    logic             hit_read;
    logic [IDX_W-1:0] word_idx;

    logic             read_valid_q;
    logic             misaligned_q;
    logic [8*W-1:0]   read_data_q;

    // A request in the reset cycle is discarded even though out_ready may still be high
    assign accept     = bus.inp_valid & bus.out_ready & ~reset;
    assign misaligned = (bus.inp_address & Addr_W'(W - 1)) != '0;
    assign word_idx   = bus.inp_address[Addr_W-1:OFF_W];
    assign hit_write  = accept & ~misaligned &  bus.inp_write_enable;
    assign hit_read   = accept & ~misaligned & ~bus.inp_write_enable;

    assign bus.out_ready      = (state == ST_RUN);
    assign bus.out_read_valid = read_valid_q;
    assign bus.out_misaligned = misaligned_q;
    assign bus.out_read_data  = read_data_q;

    // Clear sequencer: walk every word once after reset, then serve until the next reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Storage: zero fill during INIT, masked byte writes during RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (hit_write) begin
                for (int b = 0; b < W; b++) begin
                    if (bus.inp_byte_enable[b]) begin
                        mem[word_idx][8*b +: 8] <= bus.inp_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response stage: one-cycle pulses; read data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= hit_read;
            misaligned_q <= accept & misaligned;
            if (hit_read) begin
                read_data_q <= mem[word_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
// tb/tb_data_memory_be.sv - scoreboard bench for data_memory_be against a byte-array reference model
module tb_data_memory_be;
    import memory_pkg::*;

    localparam int W     = 4;
    localparam int AW    = 8;
    localparam int DEPTH = (2 ** AW) / W;
    localparam int BYTES = 2 ** AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_memory_be_if #(.W(W), .Addr_W(AW)) bus ();

    data_memory_be #(.W(W), .Addr_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        bit          mis;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  ref_mem [BYTES];
    logic [31:0] hold_data;
    int          cyc = 0;
    int          low_cnt = 0;
    bit          last_edge_reset = 1'b1;
    bit          armed = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_read(input int a);
        logic [31:0] r;
        for (int i = 0; i < W; i++) r[8*i +: 8] = ref_mem[a + i];
        return r;
    endfunction

    // Cycle bookkeeping: ready is expected once DEPTH edges have passed with reset low
    always @(posedge clk) begin
        cyc++;
        if (reset) low_cnt = 0;
        else       low_cnt++;
        last_edge_reset = reset;
    end

    // Monitor: compares DUT outputs against the scoreboard queue, mid-cycle
    always @(negedge clk) begin
        if (armed) begin
            if (last_edge_reset) hold_data = '0;
            check("out_ready", 32'(bus.out_ready), 32'(low_cnt >= DEPTH));
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("response_due_cycle", exp_q[0].due, cyc);
                mon_e = exp_q.pop_front();
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                if (mon_e.mis) begin
                    check("misaligned_pulse", 32'(bus.out_misaligned), 1);
                    check("no_read_on_misaligned", 32'(bus.out_read_valid), 0);
                    check("read_data_hold", bus.out_read_data, hold_data);
                end else begin
                    check("read_valid", 32'(bus.out_read_valid), 1);
                    check("read_data", bus.out_read_data, mon_e.data);
                    check("no_misaligned_on_read", 32'(bus.out_misaligned), 0);
                    hold_data = mon_e.data;
                end
            end else begin
                check("idle_read_valid", 32'(bus.out_read_valid), 0);
                check("idle_misaligned", 32'(bus.out_misaligned), 0);
                check("read_data_hold", bus.out_read_data, hold_data);
            end
        end
    end

    // Drive one request for one cycle and record its expected effect in the model
    task automatic req(input bit we, input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
        bit acc;
        bus.inp_valid        = 1'b1;
        bus.inp_write_enable = we;
        bus.inp_byte_enable  = be;
        bus.inp_address      = a;
        bus.inp_data         = d;
        acc = !reset && (low_cnt >= DEPTH);
        if (acc) begin
            if ((int'(a) % W) != 0) begin
                exp_q.push_back('{cyc + 1, 1'b1, 32'h0});
            end else if (we) begin
                for (int i = 0; i < W; i++) begin
                    if (be[i]) ref_mem[int'(a) + i] = d[8*i +: 8];
                end
            end else begin
                exp_q.push_back('{cyc + 1, 1'b0, ref_read(int'(a))});
            end
        end
        @(posedge clk);
        #1;
        bus.inp_valid = 1'b0;
    endtask

    task automatic idle();
        bus.inp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req();
        logic [7:0] a;
        a = 8'($urandom);
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        req(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    endtask

    // One-cycle reset with a write presented alongside it, which must be discarded
    task automatic do_reset();
        reset                = 1'b1;
        bus.inp_valid        = 1'b1;
        bus.inp_write_enable = 1'b1;
        bus.inp_byte_enable  = 4'hF;
        bus.inp_address      = 8'h04;
        bus.inp_data         = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.inp_valid = 1'b0;
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 4 * DEPTH && low_cnt < DEPTH; n++) idle();
        check("ready_within_budget", 32'(low_cnt >= DEPTH), 1);
    endtask

    initial begin
        bus.inp_valid        = 1'b0;
        bus.inp_write_enable = 1'b0;
        bus.inp_byte_enable  = '0;
        bus.inp_address      = '0;
        bus.inp_data         = '0;
        hold_data            = '0;
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;

        reset = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Requests during the clear sequence are ignored
        repeat (20) rand_req();
        wait_ready();

        // Top word reads as zero after the clear
        req(1'b0, 4'h0, 8'hFC, 32'h0);

        // Back-to-back full-word writes then reads
        req(1'b1, 4'hF, 8'h00, 32'h00000001);
        req(1'b1, 4'hF, 8'h04, 32'h00000023);
        req(1'b1, 4'hF, 8'h08, 32'h00000045);
        req(1'b0, 4'h0, 8'h00, 32'h0);
        req(1'b0, 4'h0, 8'h04, 32'h0);
        req(1'b0, 4'h0, 8'h08, 32'h0);

        // Single-byte merge
        req(1'b1, 4'b0010, 8'h08, 32'hAABBCCDD);
        req(1'b0, 4'h0, 8'h08, 32'h0);

        // Misaligned write is rejected
        req(1'b1, 4'hF, 8'h12, 32'h00000067);
        req(1'b0, 4'h0, 8'h10, 32'h0);

        // Top aligned address and an all-zero mask
        req(1'b1, 4'hF, 8'hFC, 32'hDEADBEEF);
        req(1'b1, 4'h0, 8'hFC, 32'h12345678);
        req(1'b0, 4'h0, 8'hFC, 32'h0);

        // Random traffic with occasional gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) idle();
            else rand_req();
        end

        // Reset mid-run clears contents
        do_reset();
        repeat (10) rand_req();
        // Reset again mid-clear
        do_reset();
        repeat (5) rand_req();
        wait_ready();
        req(1'b0, 4'h0, 8'h04, 32'h0);
        for (int k = 0; k < DEPTH; k++) req(1'b0, 4'h0, 8'(4 * k), 32'h0);

        for (int n = 0; n < 100; n++) rand_req();

        repeat (3) idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
